// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder
// Turns the UART receiver's byte stream into register-file and ALU control
// pulses. Frames: AA addr data (write), BB addr (read), CC op0..opN-1 fun
// (load operands then execute), DD fun (execute), EE addr count data..
// (burst write). A frame that stalls for TIMEOUT_CYCLES idle cycles, or a
// burst with count 0, is aborted with a one-cycle frame_err pulse.
//
// Ports:
//   CLK              system clock, rising edge
//   Reset            asynchronous active-low reset
//   Rx_P_Data        received byte, qualified by RxValid
//   RxValid          one-cycle data strobe
//   Reg_File_Adress  register-file address, held between strobes
//   WrEN / WrData    write strobe and data (data 0 when not writing)
//   RdEN             read strobe
//   ALU_EN / ALU_FUN ALU execute strobe and function (fun 0 when idle)
//   CLK_GATE_EN      ALU clock-gate enable, same timing as ALU_EN
//   frame_err        one-cycle pulse when a frame is aborted
//   busy             high while a frame is in progress
module rx_cmd_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int RF_DEPTH       = 16,
    parameter int NUM_OPERANDS   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic [DATA_WIDTH-1:0]       Rx_P_Data,
    input  logic                        RxValid,
    output logic [$clog2(RF_DEPTH)-1:0] Reg_File_Adress,
    output logic                        WrEN,
    output logic                        RdEN,
    output logic [DATA_WIDTH-1:0]       WrData,
    output logic                        ALU_EN,
    output logic [3:0]                  ALU_FUN,
    output logic                        CLK_GATE_EN,
    output logic                        frame_err,
    output logic                        busy
);
    localparam int AW = $clog2(RF_DEPTH);
    localparam int OW = $clog2(NUM_OPERANDS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [OW-1:0] OP_LAST  = OW'(NUM_OPERANDS - 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPERAND, FUN, BR_ADDR, BR_CNT, BR_DATA
    } state_t;

    state_t                 state_reg, state_next;
    logic [AW-1:0]          addr_reg, addr_next;
    logic [OW-1:0]          op_cnt_reg, op_cnt_next;
    logic [7:0]             burst_cnt_reg, burst_cnt_next;
    logic [TW-1:0]          tmo_cnt_reg, tmo_cnt_next;

    logic [AW-1:0]          rf_addr_reg, rf_addr_next;
    logic                   wr_en_reg, wr_en_next;
    logic                   rd_en_reg, rd_en_next;
    logic [DATA_WIDTH-1:0]  wr_data_reg, wr_data_next;
    logic                   alu_en_reg, alu_en_next;
    logic [3:0]             alu_fun_reg, alu_fun_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   busy_reg, busy_next;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            op_cnt_reg    <= '0;
            burst_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            rf_addr_reg   <= '0;
            wr_en_reg     <= 1'b0;
            rd_en_reg     <= 1'b0;
            wr_data_reg   <= '0;
            alu_en_reg    <= 1'b0;
            alu_fun_reg   <= '0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            op_cnt_reg    <= op_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            rf_addr_reg   <= rf_addr_next;
            wr_en_reg     <= wr_en_next;
            rd_en_reg     <= rd_en_next;
            wr_data_reg   <= wr_data_next;
            alu_en_reg    <= alu_en_next;
            alu_fun_reg   <= alu_fun_next;
            frame_err_reg <= frame_err_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        op_cnt_next    = op_cnt_reg;
        burst_cnt_next = burst_cnt_reg;
        tmo_cnt_next   = '0;
        rf_addr_next   = rf_addr_reg;
        wr_en_next     = 1'b0;
        rd_en_next     = 1'b0;
        wr_data_next   = '0;
        alu_en_next    = 1'b0;
        alu_fun_next   = '0;
        frame_err_next = 1'b0;

        if (RxValid) begin
            // An accepted byte always restarts the idle window, so a byte
            // landing on the last allowed cycle beats the timeout.
            unique case (state_reg)
                IDLE: begin
                    case (Rx_P_Data[7:0])
                        8'hAA: state_next = WR_ADDR;
                        8'hBB: state_next = RD_ADDR;
                        8'hCC: begin
                            state_next  = OPERAND;
                            op_cnt_next = '0;
                        end
                        8'hDD: state_next = FUN;
                        8'hEE: state_next = BR_ADDR;
                        default: state_next = IDLE;
                    endcase
                end
                WR_ADDR: begin
                    addr_next  = Rx_P_Data[AW-1:0];
                    state_next = WR_DATA;
                end
                WR_DATA: begin
                    wr_en_next   = 1'b1;
                    rf_addr_next = addr_reg;
                    wr_data_next = Rx_P_Data;
                    state_next   = IDLE;
                end
                RD_ADDR: begin
                    rd_en_next   = 1'b1;
                    rf_addr_next = Rx_P_Data[AW-1:0];
                    state_next   = IDLE;
                end
                OPERAND: begin
                    wr_en_next   = 1'b1;
                    rf_addr_next = AW'(op_cnt_reg);
                    wr_data_next = Rx_P_Data;
                    if (op_cnt_reg == OP_LAST) begin
                        state_next  = FUN;
                        op_cnt_next = '0;
                    end else begin
                        op_cnt_next = op_cnt_reg + 1'b1;
                    end
                end
                FUN: begin
                    alu_en_next  = 1'b1;
                    alu_fun_next = Rx_P_Data[3:0];
                    state_next   = IDLE;
                end
                BR_ADDR: begin
                    addr_next  = Rx_P_Data[AW-1:0];
                    state_next = BR_CNT;
                end
                BR_CNT: begin
                    burst_cnt_next = Rx_P_Data[7:0];
                    if (Rx_P_Data[7:0] == 8'd0) begin
                        frame_err_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        state_next = BR_DATA;
                    end
                end
                BR_DATA: begin
                    wr_en_next     = 1'b1;
                    rf_addr_next   = addr_reg;
                    wr_data_next   = Rx_P_Data;
                    // AW-bit add wraps RF_DEPTH-1 back to 0
                    addr_next      = addr_reg + 1'b1;
                    burst_cnt_next = burst_cnt_reg - 1'b1;
                    if (burst_cnt_reg == 8'd1) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && TIMEOUT_CYCLES > 0) begin
            if (tmo_cnt_reg == TMO_LAST) begin
                frame_err_next = 1'b1;
                state_next     = IDLE;
                op_cnt_next    = '0;
                burst_cnt_next = '0;
            end else begin
                tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
        end

        busy_next = (state_next != IDLE);
    end

    assign Reg_File_Adress = rf_addr_reg;
    assign WrEN            = wr_en_reg;
    assign RdEN            = rd_en_reg;
    assign WrData          = wr_data_reg;
    assign ALU_EN          = alu_en_reg;
    assign ALU_FUN         = alu_fun_reg;
    assign CLK_GATE_EN     = alu_en_reg;
    assign frame_err       = frame_err_reg;
    assign busy            = busy_reg;
endmodule
